// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and
// sticky overflow/underflow error flags.
//
// Build option: define FIFO_FWFT_EN for first-word fall-through
// (data_out shows the head word combinationally). Without it, data_out
// is a register loaded on an accepted read, valid one cycle after RE.
//
// Access rules (WE/RE are requests, there is no ready output):
//   read accepted  = RE && !empty
//   write accepted = WE && (!full || read accepted)
// A refused write sets overflow, a read request while empty sets
// underflow; both stay set until reset or clear. clear outranks WE/RE.
module fifo_param #(
   parameter int WIDTH     = 6,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     WE,
   input  logic                     RE,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [31:0]   AF_U   = AF_THRESH;
   localparam logic [31:0]   AE_U   = AE_THRESH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_acc;
   logic             wr_acc;

   // Flags are pure decodes of the count register.
   assign empty        = (count == '0);
   assign full         = (count == FULL_C);
   assign almost_full  = (32'(count) >= AF_U);
   assign almost_empty = (32'(count) <= AE_U);

   // A full FIFO may still take a write when a read frees a slot on the
   // same edge; an empty FIFO never serves a read in the write's cycle.
   assign rd_acc = RE && !empty;
   assign wr_acc = WE && (!full || rd_acc);

   // Storage array: not reset, written only by accepted writes.
   always_ff @(posedge clk) begin
      if (!clear && wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, occupancy count and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (WE && !wr_acc) overflow  <= 1'b1;
         if (RE && empty)   underflow <= 1'b1;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word is always presented; meaningless while empty.
   assign data_out = mem[rd_ptr];
`else
   // Registered read port: loads the head word on an accepted read, holds otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out <= '0;
      end else if (clear) begin
         data_out <= '0;
      end else if (rd_acc) begin
         data_out <= mem[rd_ptr];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param (WIDTH=6, DEPTH=16,
// AF_THRESH=14, AE_THRESH=2). Works with or without FIFO_FWFT_EN.
module tb_fifo_param;

   localparam int WIDTH = 6;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             WE;
   logic             RE;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             empty, full, almost_full, almost_empty;
   logic [CW-1:0]    count;
   logic             overflow, underflow;

   always #5 clk = ~clk;

   fifo_param #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .WE(WE), .RE(RE),
      .data_in(data_in), .data_out(data_out),
      .empty(empty), .full(full), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   // ---------------- scoreboard state ----------------
   logic [WIDTH-1:0] exp_q[$];
   logic             ovf_m;
   logic             unf_m;
   logic [WIDTH-1:0] dout_m;
   int               total = 0;
   int               bad   = 0;

   typedef struct {
      logic             we;
      logic             re;
      logic [WIDTH-1:0] din;
      int               cnt;
      logic             ae;
      logic             af;
      logic             fl;
      logic             em;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      ovf_m  = 1'b0;
      unf_m  = 1'b0;
      dout_m = '0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Inputs are driven 1 time unit after an edge, outputs sampled 1 after the next.
   task automatic cycle(input logic we_i, input logic re_i, input logic clr_i,
                        input logic [WIDTH-1:0] din_i, input string tag);
      int               sz;
      logic             rd;
      logic             wr;
      logic [WIDTH-1:0] popped;
      sz     = exp_q.size();
      rd     = re_i && !clr_i && (sz > 0);
      wr     = we_i && !clr_i && ((sz < DEPTH) || rd);
      popped = '0;
      WE = we_i; RE = re_i; clear = clr_i; data_in = din_i;
      if (clr_i) begin
         model_reset();
      end else begin
         if (we_i && !wr) ovf_m = 1'b1;
         if (re_i && sz == 0) unf_m = 1'b1;
         if (rd) popped = exp_q.pop_front();
         if (wr) exp_q.push_back(din_i);
      end
`ifdef FIFO_FWFT_EN
      #1;
      if (rd) check({tag, ".head"}, 32'(data_out), 32'(popped));
`endif
      @(posedge clk);
      #1;
      WE = 1'b0; RE = 1'b0; clear = 1'b0;
`ifndef FIFO_FWFT_EN
      if (rd) dout_m = popped;
      check({tag, ".data_out"}, 32'(data_out), 32'(dout_m));
`endif
      check({tag, ".count"},     32'(count),        32'(exp_q.size()));
      check({tag, ".empty"},     32'(empty),        32'(exp_q.size() == 0));
      check({tag, ".full"},      32'(full),         32'(exp_q.size() == DEPTH));
      check({tag, ".af"},        32'(almost_full),  32'(exp_q.size() >= AF));
      check({tag, ".ae"},        32'(almost_empty), 32'(exp_q.size() <= AE));
      check({tag, ".overflow"},  32'(overflow),     32'(ovf_m));
      check({tag, ".underflow"}, 32'(underflow),    32'(unf_m));
   endtask

   function automatic void add(input logic we, input logic re, input logic [WIDTH-1:0] din,
                               input int cnt, input logic ae, input logic af,
                               input logic fl, input logic em);
      vec_t v;
      v.we = we; v.re = re; v.din = din; v.cnt = cnt;
      v.ae = ae; v.af = af; v.fl = fl; v.em = em;
      vecs.push_back(v);
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [WIDTH-1:0] fill_words [16];
      logic [WIDTH-1:0] val;

      reset = 1'b0; clear = 1'b0; WE = 1'b0; RE = 1'b0; data_in = '0;
      model_reset();

      // Threshold table: starts from an empty FIFO, literal expectations.
      //   we    re    din    cnt  ae    af    full  empty
      add(1'b1, 1'b0, 6'h01,  1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h02,  2, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h03,  3, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 6'h00,  2, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h04,  3, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 6'h05,  3, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h06,  4, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h07,  5, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h08,  6, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h09,  7, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0A,  8, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0B,  9, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0C, 10, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0D, 11, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0E, 12, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h0F, 13, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h10, 14, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h11, 15, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 6'h12, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b1, 6'h13, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 6'h00, 15, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 6'h00, 14, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 6'h00, 13, 1'b0, 1'b0, 1'b0, 1'b0);

      fill_words[0] = 6'h20; fill_words[1] = 6'h02;
      fill_words[2] = 6'h34; fill_words[3] = 6'h0F;
      for (int i = 4; i < 16; i++) fill_words[i] = 6'(6'h10 + (i - 4));

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst.empty",     32'(empty),        32'd1);
      check("rst.full",      32'(full),         32'd0);
      check("rst.count",     32'(count),        32'd0);
      check("rst.ae",        32'(almost_empty), 32'd1);
      check("rst.af",        32'(almost_full),  32'd0);
      check("rst.overflow",  32'(overflow),     32'd0);
      check("rst.underflow", 32'(underflow),    32'd0);
`ifndef FIFO_FWFT_EN
      check("rst.data_out",  32'(data_out),     32'd0);
`endif
      @(posedge clk);
      #1;

      // Fill 16 words.
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, fill_words[i], "fill");
      check("fill.full_lit",  32'(full),  32'd1);
      check("fill.count_lit", 32'(count), 32'd16);

      // Simultaneous read+write while full: count holds, no overflow.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 6'(6'h11 + i), "rw_full");
      check("rw_full.count_lit", 32'(count),    32'd16);
      check("rw_full.ovf_lit",   32'(overflow), 32'd0);

      // Write while full: dropped, overflow set.
      cycle(1'b1, 1'b0, 1'b0, 6'h3F, "ovf");
      check("ovf.flag_lit",  32'(overflow), 32'd1);
      check("ovf.count_lit", 32'(count),    32'd16);

      // Drain: 0x10..0x1B then 0x11..0x14; 0x3F must not appear.
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, '0, "drain");
      check("drain.empty_lit", 32'(empty), 32'd1);

      // Read on empty: underflow set, overflow still sticky.
      cycle(1'b0, 1'b1, 1'b0, '0, "unf");
      check("unf.flag_lit",  32'(underflow), 32'd1);
      check("unf.count_lit", 32'(count),     32'd0);
      check("unf.ovf_lit",   32'(overflow),  32'd1);

      // Read+write on empty: only the write lands.
      cycle(1'b1, 1'b1, 1'b0, 6'h05, "rw_empty");
      check("rw_empty.count_lit", 32'(count),     32'd1);
      check("rw_empty.unf_lit",   32'(underflow), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, '0, "rw_empty_rd");
`ifndef FIFO_FWFT_EN
      check("rw_empty_rd.data_lit", 32'(data_out), 32'h05);
`endif

      // Clear with a write in the same cycle: write discarded, flags cleared.
      cycle(1'b1, 1'b0, 1'b0, 6'h2B, "pre_clr");
      cycle(1'b1, 1'b0, 1'b1, 6'h2A, "clr");
      check("clr.count_lit", 32'(count),     32'd0);
      check("clr.empty_lit", 32'(empty),     32'd1);
      check("clr.ovf_lit",   32'(overflow),  32'd0);
      check("clr.unf_lit",   32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
      check("clr.data_lit",  32'(data_out),  32'd0);
`endif

      // Threshold table.
      foreach (vecs[k]) begin
         cycle(vecs[k].we, vecs[k].re, 1'b0, vecs[k].din, $sformatf("vec%0d", k));
         check($sformatf("vec%0d.cnt_lit", k),   32'(count),        32'(vecs[k].cnt));
         check($sformatf("vec%0d.ae_lit", k),    32'(almost_empty), 32'(vecs[k].ae));
         check($sformatf("vec%0d.af_lit", k),    32'(almost_full),  32'(vecs[k].af));
         check($sformatf("vec%0d.full_lit", k),  32'(full),         32'(vecs[k].fl));
         check($sformatf("vec%0d.empty_lit", k), 32'(empty),        32'(vecs[k].em));
      end
      while (exp_q.size() > 0) cycle(1'b0, 1'b1, 1'b0, '0, "tbl_drain");

      // 40 interleaved write/read pairs with an incrementing pattern.
      for (int i = 0; i < 40; i++) begin
         val = 6'(i + 7);
         cycle(1'b1, 1'b0, 1'b0, val, "wrap_wr");
         cycle(1'b0, 1'b1, 1'b0, '0, "wrap_rd");
      end

      // Random traffic with occasional clears.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 39) == 0), 6'($urandom_range(0, 63)), "rand");
      end

      // Asynchronous reset in the middle of a cycle.
      cycle(1'b1, 1'b0, 1'b0, 6'h15, "pre_arst");
      cycle(1'b1, 1'b0, 1'b0, 6'h16, "pre_arst");
      reset = 1'b0;
      #2;
      check("arst.count",     32'(count),     32'd0);
      check("arst.empty",     32'(empty),     32'd1);
      check("arst.overflow",  32'(overflow),  32'd0);
      check("arst.underflow", 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
      check("arst.data_out",  32'(data_out),  32'd0);
`endif
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 6'h2C, "post_arst");
      cycle(1'b0, 1'b1, 1'b0, '0, "post_arst_rd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the fixed 6-bit FIFO used between the controller/PPU/APU producer and consumer paths. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in the NES core that runs in the same clock domain.

Parameters:
WIDTH, 6, data word width in bits (1..32)
DEPTH, 16, number of entries; must be a power of 2, range 2..256
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous active-low reset (0 = reset)
clear  in  1  synchronous flush, active-high
WE  in  1  write enable
RE  in  1  read enable
data_in  in  WIDTH  write data
data_out  out  WIDTH  read data
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is held as a separate register.
- Reset (reset == 0, asynchronous): wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0, data_out = 0. Therefore empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0). Array contents are not reset.
- Accepted write: WE && (!full || RE_accepted). data_in is stored at wr_ptr and wr_ptr increments on the same rising edge.
- Accepted read: RE && !empty. rd_ptr increments on the same edge.
- count update: +1 on write only, -1 on read only, unchanged when both are accepted.
- All flags are combinational from the count register, so they update in the cycle after the edge that changes count.
- Full and RE and WE together: both are accepted. The oldest word is read, the new word is written, and count stays at DEPTH. overflow is not set.
- Empty and RE and WE together: only the write is accepted, count becomes 1, and underflow is set.
- WE while full without RE: the write is dropped and overflow is set to 1. The pointer and array are unchanged.
- RE while empty: the read is ignored and underflow is set to 1.
- overflow and underflow stay set until reset or clear.
- clear: has priority over WE and RE in the same cycle. It zeroes both pointers, count, overflow, underflow and data_out on the next edge. Any write presented in that cycle is discarded.
- Reset mid-operation: asynchronous reset wins immediately. Pointers and flags go to their reset values without waiting for a clock edge.
- No internal state machine beyond the pointer and count registers. Pointer wrap from DEPTH-1 to 0 is required to be seamless.

Optional Feature:
Macro: FIFO_FWFT_EN
- Defined (first-word fall-through): data_out = mem[rd_ptr] combinationally. The head word is visible whenever empty == 0, and RE acts as "pop". data_out is don't-care while empty.
- Not defined (registered read): data_out is a register loaded with mem[rd_ptr] on the edge of an accepted read, so data is valid one cycle after RE. data_out holds its value otherwise, including on reads ignored while empty. It is cleared by reset or clear.

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release -> empty = 1, full = 0, count = 0, overflow = underflow = 0, data_out = 0.
- Fill/drain, DEPTH = 16, WIDTH = 6, non-FWFT: write 0x20, 0x02, 0x34, 0x0F, 0x10..0x1B (16 words) -> full = 1 and count = 16 after the last edge. Then read 16 words -> data_out sequence matches the write order, each one cycle after its RE, and empty = 1 at the end.
- Overflow/underflow: with full, pulse WE alone with data_in = 0x3F -> overflow = 1, count = 16, and 0x3F never appears on reads. Drain, then pulse RE on empty -> underflow = 1, count = 0. Both flags stay set until clear.
- Simultaneous access: while full, pulse RE and WE for 4 cycles with data_in 0x11..0x14 -> count stays 16, no overflow, and the tail reads 0x11..0x14. While empty, pulse RE and WE with 0x05 -> count = 1, underflow = 1, and the next read returns 0x05.
- Thresholds: AF_THRESH = 14, AE_THRESH = 2. Write 3 words -> almost_empty goes to 0 at count 3. Continue writing -> almost_full goes to 1 at count 14.
- Wrap and clear: perform 40 interleaved writes and reads (pointers wrap twice) with an incrementing pattern -> no data corruption. Assert clear with WE = 1 -> count = 0, empty = 1, flags = 0, and the write is discarded. With FIFO_FWFT_EN defined, repeat fill/drain -> data_out equals the head word with zero latency.
